branch_cmp_serial: RTL
======================

Name: branch_cmp_serial

Overview:
- Multi-cycle RV32I branch comparator. Takes two register operands and a branch funct3, and produces the branch-taken decision plus eq/lt/ltu flags.
- Compares DIGIT_W bits per cycle, MSB first. Each digit's bitwise equality is the per-bit XNOR of the operand bits, reduced with AND.
- Sits between the register-read stage and PC-select logic.
- Valid/ready on both sides.

Parameters:
- XLEN, 32, operand width.
- DIGIT_W, 4, bits compared per cycle. XLEN % DIGIT_W must be 0; otherwise fail elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/funct3 valid.
- in_ready  out  1  block can accept (high only in IDLE).
- rs1  in  XLEN  first operand.
- rs2  in  XLEN  second operand.
- funct3  in  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- taken  out  1  branch condition true.
- eq  out  1  rs1 == rs2.
- lt  out  1  signed rs1 < rs2.
- ltu  out  1  unsigned rs1 < rs2.
- illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Reset: clk and rst as above; rst is asynchronous active-high.
  - State IDLE; in_ready=1; out_valid=0.
  - taken, eq, lt, ltu, illegal all 0.
  - Shift regs and digit counter cleared; decided=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Capture rs1/rs2 into shift regs s1/s2 and latch funct3.
    - Latch sign1=rs1[XLEN-1], sign2=rs2[XLEN-1].
    - Clear decided/ltu_acc; cnt=0.
    - Go to BUSY.
- BUSY (one digit per cycle):
  - Digit pair = s1/s2[XLEN-1 -: DIGIT_W].
  - dig_eq = AND of per-bit XNOR of the pair.
  - If !decided && !dig_eq: decided<=1; ltu_acc <= (d1 < d2) unsigned.
  - Once decided=1, further digits do not change ltu_acc.
  - Shift s1/s2 left by DIGIT_W; cnt++.
  - When cnt == XLEN/DIGIT_W-1 at the clock edge, go to DONE.
- Latency: fixed at XLEN/DIGIT_W cycles (8 at defaults). out_valid rises exactly N clock edges after the accepting edge. No early exit.
- DONE:
  - out_valid=1; in_ready=0; outputs are registered.
    - eq = !decided.
    - ltu = ltu_acc.
    - lt = (sign1 != sign2) ? sign1 : ltu_acc.
    - taken: BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
    - illegal=1 and taken=0 for funct3 010/011.
  - All outputs hold stable while out_ready=0.
  - On out_ready: go to IDLE next cycle; out_valid drops.
  - No same-cycle accept of a new op in DONE; in_ready rises the cycle after handoff.
- in_valid outside IDLE is ignored. Input operands need not be held after acceptance.
- rst asserted in any state (including mid-BUSY or DONE): immediate return to reset values; the in-flight op is discarded with no out_valid.
- Flags eq/lt/ltu/taken are don't-care-free: always driven 0 when out_valid=0.

Decomposition:
- Shared package rv32_branch_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State enum/encoding for IDLE/BUSY/DONE.
- One combinational sub-module, cmp_digit (param W):
  - Inputs a[W], b[W].
  - Outputs eq (AND-reduced bitwise XNOR) and lt (unsigned a<b).
- FSM, counter and shift regs live in branch_cmp_serial.

Test Plan (XLEN=32, DIGIT_W=4):
1. BEQ, rs1=rs2=0xDEADBEEF -> out_valid exactly 8 cycles after accept; eq=1, taken=1, lt=0, ltu=0.
2. BLT, rs1=0xFFFFFFFF, rs2=0x00000001 -> lt=1, ltu=0, taken=1. Repeat as BLTU -> taken=0.
3. BGE, rs1=0x80000000, rs2=0x7FFFFFFF -> lt=1, taken=0. BGEU same operands -> ltu=0, taken=1. BNE, rs1=0x00000010, rs2=0x00000011 (difference in last digit) -> eq=0, taken=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid meanwhile -> outputs stable, in_ready=0, new op not accepted. On out_ready=1: in_ready=1 on the next cycle.
5. Assert rst for 1 cycle at BUSY cycle 3 -> out_valid never rises, in_ready=1 after reset. A following BEQ 5 vs 5 completes with taken=1 after 8 cycles.
6. funct3=3'b010, any operands -> illegal=1, taken=0, eq/lt/ltu still correct.

Source files
------------

// File: rtl/rv32_branch_pkg.sv
// Shared definitions for the RV32I serial branch comparator.
//   - funct3 encodings of the six conditional branches
//   - FSM state encoding
//   - helpers that map (funct3, eq, lt, ltu) to the branch decision
package rv32_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 010 and 011 are the only unused funct3 codes in the branch opcode space.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational comparison of one digit pair.
//   a, b : W-bit digits
//   eq   : a == b (AND-reduced bitwise XNOR)
//   lt   : unsigned a < b
module cmp_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = &(a ~^ b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_cmp_serial.sv
// Multi-cycle RV32I branch comparator. Compares DIGIT_W bits per cycle,
// MSB first; the first unequal digit settles both equality and the
// unsigned order, the sign bits then resolve the signed order.
// Latency is fixed at XLEN/DIGIT_W cycles from accept to out_valid.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   rs1, rs2, funct3    : operands and branch type
//   out_valid/out_ready : result handshake
//   taken, eq, lt, ltu  : branch decision and flags (0 unless out_valid)
//   illegal             : funct3 is 010/011 (taken forced 0)
import rv32_branch_pkg::*;

module branch_cmp_serial #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic            illegal
);

  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (XLEN % DIGIT_W != 0) begin : g_bad_digit_w
    $error("branch_cmp_serial: XLEN must be a multiple of DIGIT_W");
  end

  state_t            state_q, state_d;
  logic [XLEN-1:0]   s1_q, s2_q;
  logic [2:0]        f3_q;
  logic              sign1_q, sign2_q;
  logic              decided_q, ltu_acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              eq_q, lt_q, ltu_q, taken_q, illegal_q;

  logic dig_eq, dig_lt;
  logic accept, last_digit, handoff;
  logic decided_n, ltu_n, lt_n;

  cmp_digit #(.W(DIGIT_W)) u_cmp_digit (
    .a  (s1_q[XLEN-1 -: DIGIT_W]),
    .b  (s2_q[XLEN-1 -: DIGIT_W]),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_digit = (state_q == ST_BUSY) && (cnt_q == CNT_W'(NDIG - 1));
  assign handoff    = (state_q == ST_DONE) && out_ready;

  // Verdict including the digit being compared this cycle, so the
  // registered outputs are ready on the same edge that enters DONE.
  assign decided_n = decided_q || !dig_eq;
  assign ltu_n     = decided_q ? ltu_acc_q : (!dig_eq && dig_lt);
  assign lt_n      = (sign1_q != sign2_q) ? sign1_q : ltu_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_BUSY;
      ST_BUSY: if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      f3_q      <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      decided_q <= 1'b0;
      ltu_acc_q <= 1'b0;
      cnt_q     <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      s1_q      <= rs1;
      s2_q      <= rs2;
      f3_q      <= funct3;
      sign1_q   <= rs1[XLEN-1];
      sign2_q   <= rs2[XLEN-1];
      decided_q <= 1'b0;
      ltu_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (state_q == ST_BUSY) begin
      // The first differing digit freezes the unsigned verdict.
      if (!decided_q && !dig_eq) begin
        decided_q <= 1'b1;
        ltu_acc_q <= dig_lt;
      end
      s1_q  <= s1_q << DIGIT_W;
      s2_q  <= s2_q << DIGIT_W;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_digit) begin
        eq_q      <= !decided_n;
        ltu_q     <= ltu_n;
        lt_q      <= lt_n;
        illegal_q <= f3_illegal(f3_q);
        taken_q   <= branch_taken(f3_q, !decided_n, lt_n, ltu_n);
      end
    end else if (handoff) begin
      // Flags read 0 whenever out_valid is low.
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  assign eq      = eq_q;
  assign lt      = lt_q;
  assign ltu     = ltu_q;
  assign taken   = taken_q;
  assign illegal = illegal_q;

endmodule
